rom_arbiter: RTL and testbench

- Shares the single-port, synchronous 256x32 program/data ROM (`address`, `clock`, `q`) between two requesters, e.g. instruction fetch and a display/table reader.
- Each requester asks for a burst: a start address and a word count.
- The arbiter grants bursts round-robin, drives the ROM address sequentially and accounts for the fixed ROM read latency.
- It returns tagged, registered data words to the owning requester.

---
 rtl/rom_arbiter.sv | 176 +++++++++++++++++
 tb/tb_rom_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin burst arbiter sharing one synchronous ROM between two requesters.
// Issues sequential addresses and returns tagged, registered words to the owner.
module rom_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] start0,
  input  logic [LEN_W-1:0]  len0,
  output logic              busy0,
  output logic              valid0,
  output logic [DATA_W-1:0] data0,
  output logic              done0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] start1,
  input  logic [LEN_W-1:0]  len1,
  output logic              busy1,
  output logic              valid1,
  output logic [DATA_W-1:0] data1,
  output logic              done1,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q
);

  localparam logic [ADDR_W-1:0] AddrOne = 1;
  localparam logic [LEN_W-1:0]  LenOne  = 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    left_q, left_d;
  logic                busy0_q, busy0_d, busy1_q, busy1_d;

  // Tag pipeline: one stage per cycle of ROM latency; the output registers form the last stage.
  logic [RD_LAT-1:0]   pv_q, pv_d;
  logic [RD_LAT-1:0]   pl_q, pl_d;
  logic [RD_LAT-1:0]   po_q, po_d;

  logic                valid0_q, valid0_d, valid1_q, valid1_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0]   data0_q, data0_d, data1_q, data1_d;

  logic                gnt_sel;
  logic                tag_v, tag_l;
  logic                out_v, out_l, out_o;

  // Tie goes to the requester that did not win last time.
  assign gnt_sel = (req0 && req1) ? ~last_grant_q : req1;

  assign tag_v = (state_q == StIssue);
  assign tag_l = tag_v && (left_q == '0);

  assign out_v = pv_q[RD_LAT-1];
  assign out_l = pl_q[RD_LAT-1];
  assign out_o = po_q[RD_LAT-1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    left_d       = left_q;
    busy0_d      = busy0_q;
    busy1_d      = busy1_q;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          addr_d       = gnt_sel ? start1 : start0;
          left_d       = gnt_sel ? len1 : len0;
          busy0_d      = ~gnt_sel;
          busy1_d      = gnt_sel;
          last_grant_d = gnt_sel;
          owner_d      = gnt_sel;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (left_q == '0) begin
          state_d = StDrain;
        end else begin
          addr_d = addr_q + AddrOne;
          left_d = left_q - LenOne;
        end
      end
      StDrain: begin
        // The last word is on the outputs this cycle; release on this edge.
        if (done0_q || done1_q) begin
          busy0_d = 1'b0;
          busy1_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pv_d = pv_q;
    pl_d = pl_q;
    po_d = po_q;
    for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
      po_d[i] = po_q[i-1];
    end
    pv_d[0] = tag_v;
    pl_d[0] = tag_l;
    po_d[0] = owner_q;
  end

  always_comb begin
    valid0_d = out_v && !out_o;
    valid1_d = out_v && out_o;
    done0_d  = valid0_d && out_l;
    done1_d  = valid1_d && out_l;
    data0_d  = valid0_d ? rom_q : data0_q;
    data1_d  = valid1_d ? rom_q : data1_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      left_q       <= '0;
      busy0_q      <= 1'b0;
      busy1_q      <= 1'b0;
      pv_q         <= '0;
      pl_q         <= '0;
      po_q         <= '0;
      valid0_q     <= 1'b0;
      valid1_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      data0_q      <= '0;
      data1_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      left_q       <= left_d;
      busy0_q      <= busy0_d;
      busy1_q      <= busy1_d;
      pv_q         <= pv_d;
      pl_q         <= pl_d;
      po_q         <= po_d;
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
    end
  end

  assign busy0       = busy0_q;
  assign busy1       = busy1_q;
  assign valid0      = valid0_q;
  assign valid1      = valid1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign data0       = data0_q;
  assign data1       = data1_q;
  assign rom_address = addr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios then random traffic, scored against a
// burst-schedule model (grant cycle + closed-form offsets for busy/valid/done/address).
module tb_rom_arbiter;

  localparam int RD_LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_v;
  logic [7:0]  start_v [2];
  logic [7:0]  len_v [2];
  logic        busy0, valid0, done0, busy1, valid1, done1;
  logic [31:0] data0, data1;
  logic [7:0]  rom_address;
  logic [31:0] rom_q;
  logic [7:0]  a_hist [RD_LAT];

  always #5 clock = ~clock;

  rom_arbiter #(
    .ADDR_W (8),
    .DATA_W (32),
    .RD_LAT (RD_LAT),
    .LEN_W  (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req0        (req_v[0]),
    .start0      (start_v[0]),
    .len0        (len_v[0]),
    .busy0       (busy0),
    .valid0      (valid0),
    .data0       (data0),
    .done0       (done0),
    .req1        (req_v[1]),
    .start1      (start_v[1]),
    .len1        (len_v[1]),
    .busy1       (busy1),
    .valid1      (valid1),
    .data1       (data1),
    .done1       (done1),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  // ROM: word at addr is 0xA5A50000|addr, visible RD_LAT cycles after the address.
  always @(posedge clock) begin
    a_hist[0] <= rom_address;
    for (int i = 1; i < RD_LAT; i++) a_hist[i] <= a_hist[i-1];
  end
  assign rom_q = 32'hA5A50000 | {24'h0, a_hist[RD_LAT-1]};

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;

  // Model: one burst at a time, described by its busy-rise cycle, owner, start and length.
  bit          have_burst;
  int          b_cyc, b_start, b_n;
  int          b_own;
  bit          last_g;
  logic [7:0]  e_addr;
  logic [31:0] e_data [2];
  bit          gnt_ev;
  int          gnt_who;
  bit          auto_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    have_burst = 0;
    last_g     = 1;
    e_addr     = 8'h00;
    e_data[0]  = 32'h0;
    e_data[1]  = 32'h0;
  endtask

  // Check this cycle's outputs, let the model see this cycle's inputs, advance one clock.
  task automatic step();
    logic [1:0] eb, ev, ed;
    int         t;
    bit         idle;
    int         sel;
    eb = 2'b00; ev = 2'b00; ed = 2'b00; idle = 1;
    if (have_burst) begin
      t = cyc - b_cyc;
      if (t <= RD_LAT + b_n) begin
        idle = 0;
        eb[b_own] = 1'b1;
        if (t < b_n) e_addr = 8'((b_start + t) % 256);
        if (t > RD_LAT) begin
          ev[b_own] = 1'b1;
          e_data[b_own] = 32'hA5A50000 | 32'((b_start + t - RD_LAT - 1) % 256);
          if (t == RD_LAT + b_n) ed[b_own] = 1'b1;
        end
      end
    end
    chk("busy0", busy0, eb[0]);
    chk("busy1", busy1, eb[1]);
    chk("valid0", valid0, ev[0]);
    chk("valid1", valid1, ev[1]);
    chk("done0", done0, ed[0]);
    chk("done1", done1, ed[1]);
    chk("data0", data0, e_data[0]);
    chk("data1", data1, e_data[1]);
    chk("rom_address", rom_address, e_addr);

    gnt_ev = 0;
    if (reset) begin
      model_reset();
    end else if (idle && (req_v != 2'b00)) begin
      sel        = (req_v == 2'b11) ? (last_g ? 0 : 1) : (req_v[1] ? 1 : 0);
      have_burst = 1;
      b_cyc      = cyc + 1;
      b_own      = sel;
      b_start    = int'(start_v[sel]);
      b_n        = int'(len_v[sel]) + 1;
      last_g     = (sel == 1);
      gnt_ev     = 1;
      gnt_who    = sel;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (gnt_ev && auto_drop) req_v[gnt_who] = 1'b0;
  endtask

  function automatic logic [7:0] rand_len();
    if ($urandom_range(0, 39) == 0) return 8'hFF;
    return 8'($urandom_range(0, 6));
  endfunction

  task automatic set_req(input int r, input logic [7:0] s, input logic [7:0] l);
    req_v[r]   = 1'b1;
    start_v[r] = s;
    len_v[r]   = l;
  endtask

  initial begin
    reset      = 1'b1;
    req_v      = 2'b00;
    start_v[0] = 8'h00; start_v[1] = 8'h00;
    len_v[0]   = 8'h00; len_v[1]   = 8'h00;
    auto_drop  = 1;
    gnt_ev     = 0;
    gnt_who    = 0;
    @(posedge clock);
    #1;
    cyc = 1;
    model_reset();

    // Reset held, then single word from requester 0.
    step(); step();
    reset = 1'b0;
    set_req(0, 8'h10, 8'h00);
    repeat (8) step();

    // Four-word burst from requester 1.
    set_req(1, 8'h20, 8'h03);
    repeat (12) step();

    // Address wrap 0xFE..0x01.
    set_req(0, 8'hFE, 8'h03);
    repeat (12) step();

    // Continuous contention from reset: grants must alternate starting with 0.
    auto_drop = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 8'h30, 8'h01);
    set_req(1, 8'h50, 8'h01);
    repeat (40) step();
    req_v = 2'b00;
    auto_drop = 1;
    repeat (8) step();

    // Reset four cycles into a burst, then requester 1 served from a clean idle.
    set_req(0, 8'h40, 8'h07);
    step();
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    set_req(1, 8'h60, 8'h02);
    repeat (12) step();

    // Requester 1 arrives mid-burst, and requester 0 scribbles its inputs meanwhile.
    set_req(0, 8'h70, 8'h05);
    repeat (3) step();
    set_req(1, 8'h80, 8'h01);
    start_v[0] = 8'h99;
    len_v[0]   = 8'h20;
    repeat (20) step();

    // Random traffic: holds, re-competes, early drops, input churn and occasional resets.
    auto_drop = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (gnt_ev && gnt_who == r) begin
          if ($urandom_range(0, 1) == 0) req_v[r] = 1'b0;
          start_v[r] = 8'($urandom_range(0, 255));
          len_v[r]   = rand_len();
        end else if (!req_v[r]) begin
          if ($urandom_range(0, 3) == 0) set_req(r, 8'($urandom_range(0, 255)), rand_len());
        end else if ($urandom_range(0, 31) == 0) begin
          req_v[r] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          start_v[r] = 8'($urandom_range(0, 255));
          len_v[r]   = rand_len();
        end
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    req_v = 2'b00;
    repeat (300) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
